// File: rtl/chip_result_display.sv
// Result display stage behind the chip tester: latches each Done/RSLT pair,
// shows PASS/FAIL on four seven-segment digits, tallies results and releases the tester.
module chip_result_display #(
  parameter int HOLD_CYCLES     = 50000000,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = 32
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       Done,
  input  logic       RSLT,
  input  logic       Ack_Btn,
  output logic       DISP_RSLT,
  output logic [6:0] HEX3,
  output logic [6:0] HEX2,
  output logic [6:0] HEX1,
  output logic [6:0] HEX0,
  output logic       LED_Pass,
  output logic       LED_Fail,
  output logic [7:0] Pass_Count,
  output logic [7:0] Fail_Count
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    CAPTURE  = 3'd1,
    SHOW     = 3'd2,
    RELEASE  = 3'd3,
    WAIT_CLR = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);

  // Segment patterns, active-low {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_DASH = 7'h3F;
  localparam logic [6:0] SEG_P    = 7'h0C;
  localparam logic [6:0] SEG_A    = 7'h08;
  localparam logic [6:0] SEG_S    = 7'h12;
  localparam logic [6:0] SEG_F    = 7'h0E;
  localparam logic [6:0] SEG_I    = 7'h79;
  localparam logic [6:0] SEG_L    = 7'h47;

  state_t           state;
  logic [CNT_W-1:0] hold_cnt;

  logic             ack_s1;
  logic             ack_s2;
  logic [CNT_W-1:0] deb_cnt;
  logic             deb_level;
  logic             deb_prev;
  logic             press;

  // Acknowledge path: synchronise, then require a stable run before the level moves.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      ack_s1    <= 1'b0;
      ack_s2    <= 1'b0;
      deb_cnt   <= '0;
      deb_level <= 1'b0;
      deb_prev  <= 1'b0;
    end else begin
      ack_s1   <= Ack_Btn;
      ack_s2   <= ack_s1;
      deb_prev <= deb_level;
      if (ack_s2 != deb_level) begin
        if (deb_cnt == DEB_LAST) begin
          deb_level <= ack_s2;
          deb_cnt   <= '0;
        end else begin
          deb_cnt <= deb_cnt + CNT_W'(1);
        end
      end else begin
        deb_cnt <= '0;
      end
    end
  end

  // One-cycle event on a debounced rising edge; only SHOW listens to it.
  assign press = deb_level & ~deb_prev;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state      <= IDLE;
      hold_cnt   <= '0;
      DISP_RSLT  <= 1'b0;
      HEX3       <= SEG_DASH;
      HEX2       <= SEG_DASH;
      HEX1       <= SEG_DASH;
      HEX0       <= SEG_DASH;
      LED_Pass   <= 1'b0;
      LED_Fail   <= 1'b0;
      Pass_Count <= 8'd0;
      Fail_Count <= 8'd0;
    end else begin
      DISP_RSLT <= 1'b0;
      case (state)
        IDLE: begin
          if (Done) state <= CAPTURE;
        end
        CAPTURE: begin
          hold_cnt <= '0;
          LED_Pass <= RSLT;
          LED_Fail <= ~RSLT;
          if (RSLT) begin
            {HEX3, HEX2, HEX1, HEX0} <= {SEG_P, SEG_A, SEG_S, SEG_S};
            if (Pass_Count != 8'hFF) Pass_Count <= Pass_Count + 8'd1;
          end else begin
            {HEX3, HEX2, HEX1, HEX0} <= {SEG_F, SEG_A, SEG_I, SEG_L};
            if (Fail_Count != 8'hFF) Fail_Count <= Fail_Count + 8'd1;
          end
          state <= SHOW;
        end
        SHOW: begin
          hold_cnt <= hold_cnt + CNT_W'(1);
          // Timeout and press in the same cycle still yield a single release.
          if (hold_cnt == HOLD_LAST || press) begin
            DISP_RSLT <= 1'b1;
            state     <= RELEASE;
          end
        end
        RELEASE: begin
          state <= WAIT_CLR;
        end
        WAIT_CLR: begin
          if (!Done) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_chip_result_display.sv
// Bench for chip_result_display: directed and random runs against a cycle-timing
// model derived from hold/debounce rules, plus saturation and mid-run reset.
module tb_chip_result_display;

  localparam int HOLD = 20;
  localparam int DEB  = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       done;
  logic       rslt;
  logic       ack;
  logic       disp_rslt;
  logic [6:0] hex3, hex2, hex1, hex0;
  logic       led_pass, led_fail;
  logic [7:0] pass_count, fail_count;

  chip_result_display #(
    .HOLD_CYCLES    (HOLD),
    .DEBOUNCE_CYCLES(DEB),
    .CNT_W          (32)
  ) dut (
    .Clk       (clk),
    .Reset     (rst),
    .Done      (done),
    .RSLT      (rslt),
    .Ack_Btn   (ack),
    .DISP_RSLT (disp_rslt),
    .HEX3      (hex3),
    .HEX2      (hex2),
    .HEX1      (hex1),
    .HEX0      (hex0),
    .LED_Pass  (led_pass),
    .LED_Fail  (led_fail),
    .Pass_Count(pass_count),
    .Fail_Count(fail_count)
  );

  // clock / reset block
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;

  // reference model state
  int pass_n = 0;
  int fail_n = 0;
  bit seen   = 1'b0;
  bit last_r = 1'b0;

  function automatic logic [27:0] disp(input bit valid, input bit r);
    if (!valid) return {4{7'h3F}};
    if (r)      return {7'h0C, 7'h08, 7'h12, 7'h12};
    return {7'h0E, 7'h08, 7'h79, 7'h47};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // One tester handshake. poff: press start offset into SHOW (-1 = none);
  // gl: glitch length at SHOW+1; dd: extra cycles Done stays high after the pulse;
  // pre: button already held before Done rises and across SHOW entry.
  task automatic run_one(input bit r, input int poff, input int gl, input int dd, input bit pre);
    int n, p, hold_t, exp_p, drop_c, end_c, np, nf;
    logic [27:0] old_d, new_d;
    if (pre) begin
      ack = 1'b1;
      repeat (8) next_cycle();
    end
    n      = cyc;
    hold_t = n + 2 + HOLD;
    p      = n + 2 + poff;
    exp_p  = hold_t;
    // debounced event lands 2 sync + DEB cycles after the press; it counts only inside SHOW
    if (poff >= 0 && p + 2 + DEB <= hold_t - 1) exp_p = p + 2 + DEB + 1;
    drop_c = exp_p + 1 + dd;
    end_c  = drop_c;
    if (poff >= 0 && p + 10 > end_c) end_c = p + 10;
    if (pre && n + 12 > end_c) end_c = n + 12;
    end_c  = end_c + 12;
    np     = r ? ((pass_n < 255) ? pass_n + 1 : 255) : pass_n;
    nf     = r ? fail_n : ((fail_n < 255) ? fail_n + 1 : 255);
    old_d  = disp(seen, last_r);
    new_d  = disp(1'b1, r);
    for (int c = n; c <= end_c; c++) begin
      done = (c < drop_c);
      rslt = (c == n) ? ~r : r;
      ack  = (pre && c <= n + 12) || (poff >= 0 && c >= p && c < p + 10) ||
             (gl > 0 && c >= n + 3 && c < n + 3 + gl);
      @(negedge clk);
      chk("disp_rslt", 32'(disp_rslt), 32'(c == exp_p));
      if (c >= n + 2) begin
        chk("hex_new", 32'({hex3, hex2, hex1, hex0}), 32'(new_d));
        chk("leds_new", 32'({led_pass, led_fail}), 32'({r, ~r}));
        chk("pass_cnt_new", 32'(pass_count), 32'(np));
        chk("fail_cnt_new", 32'(fail_count), 32'(nf));
      end else begin
        chk("hex_old", 32'({hex3, hex2, hex1, hex0}), 32'(old_d));
        chk("leds_old", 32'({led_pass, led_fail}), seen ? 32'({last_r, ~last_r}) : 32'd0);
        chk("pass_cnt_old", 32'(pass_count), 32'(pass_n));
        chk("fail_cnt_old", 32'(fail_count), 32'(fail_n));
      end
      next_cycle();
    end
    pass_n = np;
    fail_n = nf;
    seen   = 1'b1;
    last_r = r;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_disp"}, 32'(disp_rslt), 32'd0);
    chk({tag, "_hex"}, 32'({hex3, hex2, hex1, hex0}), 32'(disp(1'b0, 1'b0)));
    chk({tag, "_leds"}, 32'({led_pass, led_fail}), 32'd0);
    chk({tag, "_pass"}, 32'(pass_count), 32'd0);
    chk({tag, "_fail"}, 32'(fail_count), 32'd0);
  endtask

  initial begin
    bit r;
    int gl, poff, dd;
    rst  = 1'b1;
    done = 1'b0;
    rslt = 1'b0;
    ack  = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_reset_outputs("reset");
    next_cycle();
    rst = 1'b0;
    next_cycle();

    // directed: hold expiry pass, hold expiry fail, clean press, glitch, coincidence, pre-held
    run_one(1'b1, -1, 0, 2, 1'b0);
    run_one(1'b0, -1, 0, 0, 1'b0);
    run_one(1'b1, 3, 0, 1, 1'b0);
    run_one(1'b0, -1, 2, 1, 1'b0);
    run_one(1'b1, HOLD - 7, 0, 8, 1'b0);
    run_one(1'b0, -1, 0, 1, 1'b1);

    // random runs
    for (int i = 0; i < 16; i++) begin
      r    = 1'($urandom_range(0, 1));
      gl   = int'($urandom_range(0, 2));
      poff = ($urandom_range(0, 2) == 0) ? -1 : int'($urandom_range(0, HOLD + 3));
      if (gl > 0 && poff >= 0 && poff < gl + 4) poff = gl + 4;
      dd   = int'($urandom_range(0, 3));
      run_one(r, poff, gl, dd, 1'b0);
    end

    // reset in the middle of SHOW
    done = 1'b1;
    rslt = 1'b1;
    repeat (6) next_cycle();
    #2 rst = 1'b1;
    #1;
    chk_reset_outputs("mid_reset");
    done = 1'b0;
    ack  = 1'b0;
    next_cycle();
    rst    = 1'b0;
    pass_n = 0;
    fail_n = 0;
    seen   = 1'b0;
    last_r = 1'b0;
    next_cycle();
    run_one(1'b0, -1, 0, 1, 1'b0);

    // saturation: 257 passes on top of a clean tally
    rst = 1'b1;
    next_cycle();
    rst    = 1'b0;
    pass_n = 0;
    fail_n = 0;
    seen   = 1'b0;
    next_cycle();
    for (int i = 0; i < 257; i++) begin
      run_one(1'b1, int'($urandom_range(0, 4)), 0, int'($urandom_range(0, 2)), 1'b0);
    end
    @(negedge clk);
    chk("pass_saturated", 32'(pass_count), 32'd255);
    chk("fail_zero", 32'(fail_count), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
